// File: rtl/sprite_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_scheduler
//
// Walks a host-written table of sprite draw jobs once per frame and feeds each
// valid entry, in ascending index order, to the single shared sprite_render
// engine. Higher indices therefore draw over lower ones.
//
// Optional feature: define SPRITE_CLIP_EN to skip entries whose drawn
// rectangle extends past the right or bottom screen edge.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_start         one-cycle pulse that starts a table walk
//   wr_en, wr_idx       table write strobe and entry index
//   wr_valid, wr_x, wr_y, wr_scale, wr_id   entry fields to write
//   rnd_rst             one-cycle renderer reset (LOAD state)
//   rnd_enable          renderer enable (RUN state)
//   rnd_sx, rnd_sy, rnd_scale, rnd_id       parameters of the sprite in flight
//   rnd_drawing         renderer busy indication
//   busy                a table walk is in progress
//   frame_done          one-cycle pulse when the walk ends
//   overrun             sticky: frame_start arrived while not idle
//   timeout_err         sticky: renderer never started within START_TIMEOUT
// -----------------------------------------------------------------------------
module sprite_scheduler #(
  parameter int NUM_SPRITES   = 8,
  parameter int CORDW         = 10,
  parameter int IDW           = 4,
  parameter int SPR_WIDTH     = 32,
  parameter int SPR_HEIGHT    = 32,
  parameter int SCREEN_W      = 800,
  parameter int SCREEN_H      = 480,
  parameter int START_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
  input  logic                           wr_valid,
  input  logic [CORDW-1:0]               wr_x,
  input  logic [CORDW-1:0]               wr_y,
  input  logic [2:0]                     wr_scale,
  input  logic [IDW-1:0]                 wr_id,
  output logic                           rnd_rst,
  output logic                           rnd_enable,
  output logic [CORDW-1:0]               rnd_sx,
  output logic [CORDW-1:0]               rnd_sy,
  output logic [2:0]                     rnd_scale,
  output logic [IDW-1:0]                 rnd_id,
  input  logic                           rnd_drawing,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic                           timeout_err
);

  localparam int IW  = $clog2(NUM_SPRITES);
  localparam int CW4 = CORDW + 4;
  localparam int TW  = $clog2(START_TIMEOUT + 1);

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LOAD, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic [2:0]       scale;
    logic [IDW-1:0]   id;
  } entry_t;

  state_t         r_state, w_next;
  entry_t         r_table [NUM_SPRITES];
  logic [IW-1:0]  r_idx;
  logic           r_seen;
  logic [TW-1:0]  r_cnt;

  entry_t         w_entry;
  logic [CW4-1:0] w_mult, w_end_x, w_end_y;
  logic           w_oob, w_clip, w_draw, w_last, w_timeout, w_complete;

  // Sprite table. The index width exactly spans the table (power-of-2 size),
  // so every write address is in range.
  // NOTE: the table is a register array, not RAM, so it can and must be
  // cleared by reset; a RAM-style table would need a clearing walk instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) r_table[i] <= '0;
    end else if (wr_en) begin
      r_table[wr_idx] <= {wr_valid, wr_x, wr_y, wr_scale, wr_id};
    end
  end

  // A write landing in the same cycle as SCAN/LOAD reads the old entry,
  // because the table only updates on the closing edge.
  assign w_entry = r_table[r_idx];

  // Bounds check in CORDW+4 bits; drawn size is SPR_*·(scale+1).
  assign w_mult  = CW4'(w_entry.scale) + CW4'(1);
  assign w_end_x = CW4'(w_entry.x) + CW4'(SPR_WIDTH) * w_mult;
  assign w_end_y = CW4'(w_entry.y) + CW4'(SPR_HEIGHT) * w_mult;
  assign w_oob   = (w_end_x > CW4'(SCREEN_W)) || (w_end_y > CW4'(SCREEN_H));
  assign w_clip  = CLIP_EN & w_oob;

  assign w_draw     = w_entry.valid & ~w_clip;
  assign w_last     = (r_idx == IW'(NUM_SPRITES - 1));
  assign w_timeout  = ~r_seen & (r_cnt == TW'(START_TIMEOUT - 1));
  assign w_complete = (r_seen & ~rnd_drawing) | w_timeout;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (frame_start) w_next = S_SCAN;
      S_SCAN: begin
        if (w_draw)      w_next = S_LOAD;
        else if (w_last) w_next = S_DONE;
      end
      S_LOAD: w_next = S_RUN;
      S_RUN:  if (w_complete) w_next = w_last ? S_DONE : S_SCAN;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = 1'b0;
    rnd_rst    = 1'b0;
    rnd_enable = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_SCAN: busy = 1'b1;
      S_LOAD: begin busy = 1'b1; rnd_rst    = 1'b1; end
      S_RUN:  begin busy = 1'b1; rnd_enable = 1'b1; end
      S_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Walk index, renderer parameters, start watchdog and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_seen      <= 1'b0;
      r_cnt       <= '0;
      rnd_sx      <= '0;
      rnd_sy      <= '0;
      rnd_scale   <= '0;
      rnd_id      <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_start && r_state != S_IDLE) overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (frame_start) r_idx <= '0;
        S_SCAN: if (!w_draw && !w_last) r_idx <= r_idx + IW'(1);
        S_LOAD: begin
          rnd_sx    <= w_entry.x;
          rnd_sy    <= w_entry.y;
          rnd_scale <= w_entry.scale;
          rnd_id    <= w_entry.id;
          r_seen    <= 1'b0;
          r_cnt     <= '0;
        end
        S_RUN: begin
          if (rnd_drawing) r_seen <= 1'b1;
          // Saturate; the count only matters until the renderer starts.
          if (r_cnt != TW'(START_TIMEOUT)) r_cnt <= r_cnt + TW'(1);
          if (w_timeout) timeout_err <= 1'b1;
          if (w_complete && !w_last) r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sprite_scheduler
//
// Directed bench for sprite_scheduler. A behavioural renderer answers the DUT,
// a frame model expands the table into the expected per-cycle output trace,
// and a compare process checks the DUT against that trace on every cycle.
// Literal expectations (latencies, enable counts, sticky flags) pin the model.
// -----------------------------------------------------------------------------
module tb_sprite_scheduler;

  localparam int N     = 8;
  localparam int SW    = 32;
  localparam int SH    = 32;
  localparam int SCR_W = 800;
  localparam int SCR_H = 480;
  localparam int TO    = 15;

  logic       clk = 1'b0;
  logic       rst, frame_start, wr_en, wr_valid;
  logic [2:0] wr_idx, wr_scale;
  logic [9:0] wr_x, wr_y;
  logic [3:0] wr_id;
  logic       rnd_rst, rnd_enable, rnd_drawing, busy, frame_done, overrun, timeout_err;
  logic [9:0] rnd_sx, rnd_sy;
  logic [2:0] rnd_scale;
  logic [3:0] rnd_id;

  always #5 clk = ~clk;

  sprite_scheduler #(
    .NUM_SPRITES(N), .CORDW(10), .IDW(4), .SPR_WIDTH(SW), .SPR_HEIGHT(SH),
    .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .START_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
    .wr_scale(wr_scale), .wr_id(wr_id),
    .rnd_rst(rnd_rst), .rnd_enable(rnd_enable), .rnd_sx(rnd_sx), .rnd_sy(rnd_sy),
    .rnd_scale(rnd_scale), .rnd_id(rnd_id), .rnd_drawing(rnd_drawing),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference renderer: drawing rises in the cycle after rnd_rst and stays
  // high for (SW*(s+1))*(SH*(s+1)) cycles. 'dead' keeps it idle.
  bit dead = 1'b0;
  bit r_first;
  int r_rem;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b0;
      r_rem   <= 0;
    end else if (rnd_rst) begin
      r_first <= !dead;
      r_rem   <= 0;
    end else if (r_first) begin
      r_first <= 1'b0;
      r_rem   <= SW * (int'(rnd_scale) + 1) * SH * (int'(rnd_scale) + 1) - 1;
    end else if (r_rem > 0 && rnd_enable) begin
      r_rem <= r_rem - 1;
    end
  end
  assign rnd_drawing = r_first || (r_rem > 0);

  // Bench copy of the table contents.
  bit t_v[N];
  int t_x[N], t_y[N], t_s[N], t_id[N];

  typedef struct packed {
    logic       busy, rs, en, done, chk;
    logic [9:0] sx, sy;
    logic [2:0] sc;
    logic [3:0] id;
  } exp_t;
  exp_t q[$];

  function automatic bit clipped(input int i);
`ifdef SPRITE_CLIP_EN
    return (t_x[i] + SW * (t_s[i] + 1) > SCR_W) || (t_y[i] + SH * (t_s[i] + 1) > SCR_H);
`else
    return 1'b0;
`endif
  endfunction

  // Expand the table into the expected output trace of one walk, starting
  // with the cycle after frame_start is sampled.
  function automatic void build_expected();
    exp_t e;
    int   len;
    for (int i = 0; i < N; i++) begin
      e = '0; e.busy = 1'b1;
      q.push_back(e);                              // scan
      if (t_v[i] && !clipped(i)) begin
        e.rs = 1'b1;
        q.push_back(e);                            // load
        e = '0; e.busy = 1'b1; e.en = 1'b1; e.chk = 1'b1;
        e.sx = 10'(t_x[i]); e.sy = 10'(t_y[i]); e.sc = 3'(t_s[i]); e.id = 4'(t_id[i]);
        len = dead ? TO : 1 + SW * SH * (t_s[i] + 1) * (t_s[i] + 1);
        for (int k = 0; k < len; k++) q.push_back(e);
      end
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endfunction

  // Per-cycle compare against the model trace; idle expected when empty.
  int en_cnt, rs_cnt, done_cnt;
  always @(negedge clk) begin
    exp_t e, a;
    e = (q.size() > 0) ? q.pop_front() : '0;
    a = '0;
    a.busy = busy; a.rs = rnd_rst; a.en = rnd_enable; a.done = frame_done; a.chk = e.chk;
    if (e.chk) begin
      a.sx = rnd_sx; a.sy = rnd_sy; a.sc = rnd_scale; a.id = rnd_id;
    end
    check("cycle_trace", a, e);
    if (rnd_enable) en_cnt++;
    if (rnd_rst)    rs_cnt++;
    if (frame_done) done_cnt++;
  end

  // Called just after a rising edge.
  task automatic wr(input int idx, input bit v, input int x, input int y, input int s, input int id);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_valid = v;
    wr_x = 10'(x); wr_y = 10'(y); wr_scale = 3'(s); wr_id = 4'(id);
    @(posedge clk); #1;
    wr_en = 1'b0;
    t_v[idx] = v; t_x[idx] = x; t_y[idx] = y; t_s[idx] = s; t_id[idx] = id;
  endtask

  // Runs one walk. ovr_at: cycle (1-based) in which to repeat frame_start,
  // 0 for none. load_wr: rewrite entry 3 (x=200) during its LOAD cycle.
  task automatic run_frame(input int ovr_at, input bit load_wr, output int lat);
    int limit;
    bit wrote;
    wrote = 1'b0;
    en_cnt = 0; rs_cnt = 0; done_cnt = 0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    build_expected();
    limit = q.size() + 10;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      frame_start = (lat == ovr_at);
      if (load_wr && rnd_rst && !wrote) begin
        wr_en = 1'b1; wr_idx = 3'd3; wr_valid = 1'b1;
        wr_x = 10'd200; wr_y = 10'd50; wr_scale = 3'd0; wr_id = 4'd2;
        wrote = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
    end while (!frame_done && lat < limit);
    check("frame_done_reached", frame_done, 1);
    frame_start = 1'b0;
    wr_en = 1'b0;
    if (wrote) t_x[3] = 200;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0;
    wr_x = '0; wr_y = '0; wr_scale = '0; wr_id = '0;
    for (int i = 0; i < N; i++) begin
      t_v[i] = 1'b0; t_x[i] = 0; t_y[i] = 0; t_s[i] = 0; t_id[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_rnd_enable", rnd_enable, 0);
    check("rst_rnd_rst", rnd_rst, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_rnd_sx", rnd_sx, 0);

    // Empty table: eight skipped entries then the done pulse.
    run_frame(0, 1'b0, lat);
    check("empty_latency", lat, 9);
    check("empty_enable_cycles", en_cnt, 0);
    check("empty_done_pulses", done_cnt, 1);

    // Single sprite at entry 3; rewrite it during its LOAD cycle.
    wr(3, 1'b1, 100, 50, 0, 2);
    run_frame(0, 1'b1, lat);
    check("e3_enable_cycles", en_cnt, 1025);
    check("e3_rst_pulses", rs_cnt, 1);
    check("e3_done_pulses", done_cnt, 1);
    check("e3_sx_old_value", rnd_sx, 100);
    check("e3_sy", rnd_sy, 50);
    check("e3_id", rnd_id, 2);

    // The rewrite shows up on the following frame.
    run_frame(0, 1'b0, lat);
    check("e3_sx_new_value", rnd_sx, 200);

    // Entries 0 (scale 1) and 5 (scale 0): 4097 + 1025 RUN cycles.
    wr(3, 1'b0, 0, 0, 0, 0);
    wr(0, 1'b1, 10, 20, 1, 5);
    wr(5, 1'b1, 300, 200, 0, 7);
    run_frame(0, 1'b0, lat);
    check("two_enable_cycles", en_cnt, 5122);
    check("two_rst_pulses", rs_cnt, 2);
    check("two_done_pulses", done_cnt, 1);
    check("two_last_id", rnd_id, 7);

    // frame_start repeated mid-walk.
    run_frame(3, 1'b0, lat);
    check("ovr_overrun", overrun, 1);
    check("ovr_enable_cycles", en_cnt, 5122);
    check("ovr_done_pulses", done_cnt, 1);
    check("ovr_no_timeout", timeout_err, 0);

    // Idle renderer: each entry times out after 15 RUN cycles.
    dead = 1'b1;
    run_frame(0, 1'b0, lat);
    check("to_timeout_err", timeout_err, 1);
    check("to_enable_cycles", en_cnt, 30);
    check("to_done_pulses", done_cnt, 1);
    dead = 1'b0;

    // Entry crossing the right screen edge (780 + 32 > 800).
    wr(0, 1'b0, 0, 0, 0, 0);
    wr(5, 1'b0, 0, 0, 0, 0);
    wr(2, 1'b1, 780, 100, 0, 3);
    run_frame(0, 1'b0, lat);
`ifdef SPRITE_CLIP_EN
    check("clip_enable_cycles", en_cnt, 0);
`else
    check("clip_enable_cycles", en_cnt, 1025);
`endif

    // Reset during RUN.
    wr(2, 1'b0, 0, 0, 0, 0);
    wr(1, 1'b1, 10, 10, 0, 1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    build_expected();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rnd_enable && lat < 50);
    check("mid_enable_seen", rnd_enable, 1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_enable", rnd_enable, 0);
    check("mid_rst_sx", rnd_sx, 0);
    check("mid_rst_id", rnd_id, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_timeout", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_v[i] = 1'b0; t_x[i] = 0; t_y[i] = 0; t_s[i] = 0; t_id[i] = 0;
    end
    run_frame(0, 1'b0, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_enable_cycles", en_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
